// File: rtl/iob_gray_counter_ud.sv
// rtl/iob_gray_counter_ud.sv - up/down binary counter with registered Gray output
// Optional load port enabled by IOB_GRAY_COUNTER_LOAD_EN.
module iob_gray_counter_ud #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter int             MODE    = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         dir_i,
`ifdef IOB_GRAY_COUNTER_LOAD_EN
    input  logic         ld_i,
    input  logic [W-1:0] ld_data_i,
`endif
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o,
    output logic         tc_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         at_max, at_min, tc;

    always_comb begin
        at_max = (bin_q == ALL_ONES);
        at_min = (bin_q == '0);
        tc     = dir_i ? at_max : at_min;
        bin_d  = bin_q;
        wrap_d = 1'b0;
`ifdef IOB_GRAY_COUNTER_LOAD_EN
        if (ld_i) begin
            bin_d = ld_data_i;
        end else
`endif
        if (en_i) begin
            // At the boundary only wrap mode moves; saturate mode holds silently.
            if (tc) begin
                if (MODE == 0) begin
                    bin_d  = dir_i ? '0 : ALL_ONES;
                    wrap_d = 1'b1;
                end
            end else begin
                bin_d = dir_i ? bin_q + 1'b1 : bin_q - 1'b1;
            end
        end
        // Gray is encoded from the next binary value so both outputs come from flops.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;
    assign wrap_o = wrap_q;
    assign tc_o   = tc;

endmodule

// File: doc/iob_gray_counter_ud.md
IOB_GRAY_COUNTER_UD -- requirements
Module: iob_gray_counter_ud

Interface
REQ-001 SHALL have parameter W, default 4, counter width in bits (W >= 1).
REQ-002 SHALL have parameter RST_VAL, default 0, binary value loaded on reset (W bits).
REQ-003 SHALL have parameter MODE, default 0, boundary behaviour: 0 = wrap, 1 = saturate.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en_i  input  1  count enable.
REQ-007 SHALL have port dir_i  input  1  count direction: 1 = up, 0 = down.
REQ-008 SHALL have port ld_i  input  1  load strobe (present only with IOB_GRAY_COUNTER_LOAD_EN).
REQ-009 SHALL have port ld_data_i  input  W  binary load value (present only with IOB_GRAY_COUNTER_LOAD_EN).
REQ-010 SHALL have port bin_o  output  W  registered binary count.
REQ-011 SHALL have port gray_o  output  W  registered Gray-coded count.
REQ-012 SHALL have port tc_o  output  1  terminal-count flag.
REQ-013 SHALL have port wrap_o  output  1  registered one-cycle wrap pulse.

Function
REQ-014 Per-edge priority SHALL be rst_i > ld_i > en_i > hold.
REQ-015 ld_i=1: bin_o <= ld_data_i, whatever en_i/dir_i; wrap_o <= 0.
REQ-016 en_i=1, dir_i=1: bin_o <= bin_o+1; en_i=1, dir_i=0: bin_o <= bin_o-1; one-cycle latency.
REQ-017 en_i=0 and ld_i=0: bin_o, gray_o hold; wrap_o <= 0.
REQ-018 gray_o SHALL always equal bin_o ^ (bin_o >> 1) in the same cycle, both from flops; gray_o never derived combinationally at the output.
REQ-019 W=1: gray_o SHALL equal bin_o.
REQ-020 Consecutive gray_o values after one count step SHALL differ in exactly one bit, including across wrap.
REQ-021 MODE=0, up at all-ones: bin_o <= 0; down at 0: bin_o <= all-ones; wrap_o <= 1 for one cycle.
REQ-022 MODE=1, up at all-ones or down at 0: bin_o holds; wrap_o stays 0.
REQ-023 wrap_o SHALL be 1 only in the cycle after a wrapping count step, else 0.
REQ-024 tc_o SHALL be combinational: 1 when (dir_i=1 and bin_o all-ones) or (dir_i=0 and bin_o=0), independent of en_i.
REQ-025 Direction change SHALL take effect on the same edge; no pipeline bubble.
REQ-026 Arithmetic SHALL be modulo 2^W; no carry out beyond W bits.

Reset
REQ-027 rst_i=1 at an edge: bin_o <= RST_VAL, gray_o <= RST_VAL ^ (RST_VAL >> 1), wrap_o <= 0, overriding ld_i and en_i.
REQ-028 Reset mid-count SHALL discard the in-flight step; first count after release starts from RST_VAL.
REQ-029 No asynchronous reset; state before the first rst_i edge is undefined.

Configuration
REQ-030 Macro IOB_GRAY_COUNTER_LOAD_EN defined: ld_i and ld_data_i exist and REQ-015 applies.
REQ-031 Macro undefined: ld_i and ld_data_i absent, load path removed; rst_i > en_i > hold.

Verification
REQ-032 W=4, RST_VAL=0: rst_i 1 cycle, en_i=1, dir_i=1 for 16 cycles -> gray_o 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap_o=1 only after F->0 step.
REQ-033 W=4, MODE=0: bin_o=0, dir_i=0, en_i=1 -> bin_o=F, gray_o=8, wrap_o=1 one cycle; tc_o=1 while bin_o=0, dir_i=0.
REQ-034 W=4, MODE=1: count up to F, hold en_i=1 3 cycles -> bin_o stays F, gray_o stays 8, wrap_o=0, tc_o=1.
REQ-035 LOAD_EN, W=4: ld_i=1, ld_data_i=A, en_i=1 -> next bin_o=A, gray_o=F; ld_i with rst_i=1 -> bin_o=RST_VAL.
REQ-036 RST_VAL=5, W=4: rst_i mid-count at bin_o=9 -> bin_o=5, gray_o=7, wrap_o=0; en_i=0 5 cycles -> outputs constant.
